// File: rtl/mccoy_host.sv
// Drives a McCoy core through io_in: it resets the core, clocks it, and answers each PC with a word fetched from a 32x6 program memory.
// The fetch takes one clk (the new word appears in the first RUN_LO cycle); there is no backpressure, and start and load_en are ignored while the block is busy.
module mccoy_host #(
  parameter int HALF_PERIOD = 2,
  parameter int MAX_CYCLES  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [4:0] load_addr,
  input  logic [5:0] load_data,
  input  logic       start,
  input  logic [7:0] core_out,
  output logic [7:0] core_io,
  output logic [7:0] pc_val,
  output logic [7:0] x8_val,
  output logic [7:0] cycle_count,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {IDLE, CRST, RUN_HI, RUN_LO, HALT} state_t;

  localparam logic [3:0] HP_LAST = 4'(HALF_PERIOD - 1);
  localparam logic [7:0] MAX_C   = 8'(MAX_CYCLES);

  state_t     state;
  logic [3:0] hp_cnt;
  logic       crst_ph;
  logic       first;
  logic       core_clk_q;
  logic       core_rst_q;
  logic [5:0] instr_q;
  logic [7:0] prev_pc;
  logic [5:0] mem [0:31];

  logic       wr_en;
  logic       hp_last;
  logic [5:0] mem0_now;
  logic [7:0] cnt_inc;

  assign wr_en    = load_en && (state == IDLE || state == HALT);
  assign hp_last  = (hp_cnt == HP_LAST);
  // A write to word 0 in the start cycle must be seen by the run it starts.
  assign mem0_now = (wr_en && load_addr == 5'd0) ? load_data : mem[0];
  assign cnt_inc  = (cycle_count == 8'hFF) ? 8'hFF : cycle_count + 8'd1;

  assign core_io = {core_clk_q, core_rst_q, instr_q};

  always_ff @(posedge clk) begin
    if (wr_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hp_cnt      <= 4'd0;
      crst_ph     <= 1'b0;
      first       <= 1'b0;
      core_clk_q  <= 1'b0;
      core_rst_q  <= 1'b1;
      instr_q     <= 6'd0;
      prev_pc     <= 8'd0;
      pc_val      <= 8'd0;
      x8_val      <= 8'd0;
      cycle_count <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= CRST;
            hp_cnt      <= 4'd0;
            crst_ph     <= 1'b0;
            core_clk_q  <= 1'b1;
            core_rst_q  <= 1'b1;
            instr_q     <= mem0_now;
            cycle_count <= 8'd0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        CRST: begin
          if (hp_last) begin
            hp_cnt <= 4'd0;
            if (!crst_ph) begin
              crst_ph    <= 1'b1;
              core_clk_q <= 1'b0;
            end else begin
              state      <= RUN_HI;
              core_clk_q <= 1'b1;
              core_rst_q <= 1'b0;
              first      <= 1'b1;
            end
          end else begin
            hp_cnt <= hp_cnt + 4'd1;
          end
        end
        RUN_HI: begin
          if (hp_last) begin
            hp_cnt     <= 4'd0;
            state      <= RUN_LO;
            core_clk_q <= 1'b0;
            prev_pc    <= pc_val;
            pc_val     <= core_out;
            instr_q    <= mem[core_out[4:0]];
          end else begin
            hp_cnt <= hp_cnt + 4'd1;
          end
        end
        RUN_LO: begin
          if (hp_last) begin
            hp_cnt      <= 4'd0;
            x8_val      <= core_out;
            cycle_count <= cnt_inc;
            first       <= 1'b0;
            // prev_pc is stale on the first cycle after core reset.
            if (!first && pc_val == prev_pc) begin
              state   <= HALT;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b0;
            end else if (cnt_inc == MAX_C) begin
              state   <= HALT;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b1;
            end else begin
              state      <= RUN_HI;
              core_clk_q <= 1'b1;
            end
          end else begin
            hp_cnt <= hp_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mccoy_host.sv
// Bench for mccoy_host: a stand-in McCoy core answers PCs; fetched words are scoreboarded against a memory model.
module tb_mccoy_host;

  localparam int HP = 2;
  localparam int MC = 10;

  logic       clk;
  logic       reset;
  logic       load_en;
  logic [4:0] load_addr;
  logic [5:0] load_data;
  logic       start;
  logic [7:0] core_out;
  logic [7:0] core_io;
  logic [7:0] pc_val;
  logic [7:0] x8_val;
  logic [7:0] cycle_count;
  logic       busy;
  logic       done;
  logic       timeout;

  mccoy_host #(.HALF_PERIOD(HP), .MAX_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .core_out(core_out),
    .core_io(core_io), .pc_val(pc_val), .x8_val(x8_val),
    .cycle_count(cycle_count), .busy(busy), .done(done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in core: PC per core cycle depends on the run mode.
  int         mode = 0;
  int         cyc_idx = 0;
  int         hi_len = 0;
  logic       prev7 = 1'b0;
  logic [7:0] pc_cur = 8'd0;
  logic [5:0] mem_model [0:31];

  assign core_out = core_io[7] ? pc_cur : (pc_cur ^ 8'h5A);

  function automatic logic [7:0] pc_fn(input int m, input int k);
    case (m)
      0:       pc_fn = (k >= 4) ? 8'd3 : 8'(k - 1);
      1:       pc_fn = (k >= 3) ? 8'h05 : 8'(k - 1);
      2:       pc_fn = 8'(k - 1);
      3:       pc_fn = 8'h25;
      default: pc_fn = 8'h00;
    endcase
  endfunction

  typedef struct {
    logic [5:0] ins;
    logic [7:0] pc;
  } exp_t;
  exp_t sb[$];
  exp_t e_push;
  exp_t e_pop;

  always @(negedge clk) begin
    if (core_io[6]) begin
      cyc_idx = 0;
      hi_len  = 0;
      sb.delete();
    end else if (core_io[7] && !prev7) begin
      cyc_idx++;
      pc_cur = pc_fn(mode, cyc_idx);
      e_push.ins = mem_model[pc_cur[4:0]];
      e_push.pc  = pc_cur;
      sb.push_back(e_push);
      hi_len = 1;
    end else if (core_io[7]) begin
      hi_len++;
    end else if (prev7 && busy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got fetch with no pending PC, required a pending PC");
      end else begin
        e_pop = sb.pop_front();
        chk("fetch_instr", 8'(core_io[5:0]), 8'(e_pop.ins));
        chk("fetch_pc_val", pc_val, e_pop.pc);
        chk("clk_high_len", 8'(hi_len), 8'(HP));
      end
    end
    prev7 = core_io[7];
  end

  typedef struct {
    int         m;
    logic [7:0] cnt;
    logic [7:0] pc;
    logic       to;
  } vec_t;
  vec_t tbl [5];

  task automatic load_word(input logic [4:0] a, input logic [5:0] d);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = a; load_data = d;
    mem_model[a] = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic wr, input logic [4:0] a, input logic [5:0] d);
    @(posedge clk); #1;
    start = 1'b1; load_en = wr; load_addr = a; load_data = d;
    if (wr) mem_model[a] = d;
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    chk("crst_core_io", core_io, {2'b11, mem_model[0]});
    chk("start_busy", 8'(busy), 8'd1);
    chk("start_done", 8'(done), 8'd0);
    chk("start_timeout", 8'(timeout), 8'd0);
    chk("start_count", cycle_count, 8'd0);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_within_budget", 8'(seen), 8'd1);
  endtask

  task automatic run_vec(input vec_t v);
    mode = v.m;
    do_start(1'b0, 5'd0, 6'd0);
    wait_done();
    chk("end_timeout", 8'(timeout), 8'(v.to));
    chk("end_count", cycle_count, v.cnt);
    chk("end_pc_val", pc_val, v.pc);
    chk("end_x8_val", x8_val, v.pc ^ 8'h5A);
    chk("end_busy", 8'(busy), 8'd0);
    chk("halt_core_io_ctl", 8'(core_io[7:6]), 8'd0);
    chk("sb_drained", 8'(sb.size()), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    tbl[0] = '{m: 0, cnt: 8'd5,  pc: 8'h03, to: 1'b0};
    tbl[1] = '{m: 1, cnt: 8'd4,  pc: 8'h05, to: 1'b0};
    tbl[2] = '{m: 2, cnt: 8'd10, pc: 8'h09, to: 1'b1};
    tbl[3] = '{m: 3, cnt: 8'd2,  pc: 8'h25, to: 1'b0};
    tbl[4] = '{m: 4, cnt: 8'd2,  pc: 8'h00, to: 1'b0};

    reset = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = 5'd0; load_data = 6'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_core_io", core_io, 8'h40);
    chk("rst_pc_val", pc_val, 8'd0);
    chk("rst_x8_val", x8_val, 8'd0);
    chk("rst_count", cycle_count, 8'd0);
    chk("rst_status", {5'd0, busy, done, timeout}, 8'd0);

    for (int i = 0; i < 32; i++) begin
      case (i)
        0:       load_word(5'(i), 6'h01);
        1:       load_word(5'(i), 6'h09);
        2:       load_word(5'(i), 6'h12);
        3:       load_word(5'(i), 6'h1B);
        default: load_word(5'(i), 6'(i * 5 + 7));
      endcase
    end

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // start and load_en while busy must both be ignored.
    mode = 2;
    do_start(1'b0, 5'd0, 6'd0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cyc_idx >= 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_run", 8'(found), 8'd1);
    start = 1'b1; load_en = 1'b1; load_addr = 5'd1; load_data = 6'h3F;
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    chk("busy_start_no_crst", 8'(core_io[6]), 8'd0);
    chk("busy_start_busy", 8'(busy), 8'd1);
    wait_done();
    chk("busy_run_count", cycle_count, 8'd10);
    chk("busy_run_timeout", 8'(timeout), 8'd1);
    run_vec(tbl[0]);

    // Reset during RUN_LO aborts at once; memory survives.
    mode = 2;
    do_start(1'b0, 5'd0, 6'd0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cyc_idx >= 3 && core_io[7:6] == 2'b00 && busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_run_lo", 8'(found), 8'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_core_io", core_io, 8'h40);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_count", cycle_count, 8'd0);
    chk("abort_pc_val", pc_val, 8'd0);
    @(posedge clk); #1 reset = 1'b1;
    run_vec(tbl[0]);

    // Write of word 0 in the start cycle is used by that run.
    mode = 0;
    do_start(1'b1, 5'd0, 6'h2A);
    wait_done();
    chk("newword_count", cycle_count, 8'd5);
    chk("newword_pc_val", pc_val, 8'h03);
    chk("newword_timeout", 8'(timeout), 8'd0);
    chk("newword_sb_drained", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mccoy_host.md
MCCOY_HOST -- requirements
Module: mccoy_host

Interface
REQ-001 Parameter HALF_PERIOD, default 2, SHALL set the clk cycles per core-clock half period (legal values 2..15).
REQ-002 Parameter MAX_CYCLES, default 200, SHALL set the number of core cycles before a run times out (legal values 1..255).
REQ-003 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 load_en  in  1  program-memory write strobe.
REQ-006 load_addr  in  5  program-memory write address.
REQ-007 load_data  in  6  program word to write.
REQ-008 start  in  1  single-cycle pulse that begins a run.
REQ-009 core_out  in  8  McCoy io_out: PC while core clock is high, x8 while core clock is low.
REQ-010 core_io  out  8  McCoy io_in: bit 7 = core clock, bit 6 = core reset (active-high), bits 5:0 = instruction.
REQ-011 pc_val  out  8  last sampled PC.
REQ-012 x8_val  out  8  last sampled x8.
REQ-013 cycle_count  out  8  core cycles completed in the current run.
REQ-014 busy  out  1  high in CRST, RUN_HI and RUN_LO.
REQ-015 done  out  1  high in HALT.
REQ-016 timeout  out  1  high in HALT when the run ended on MAX_CYCLES.

Function
REQ-017 The block SHALL hold a 32x6 program memory; memory contents SHALL NOT be cleared by reset.
REQ-018 A load_en write SHALL occur only in IDLE or HALT; load_en in other states SHALL be ignored.
REQ-019 The FSM states SHALL be IDLE, CRST, RUN_HI, RUN_LO and HALT, with a half-period counter from 0 to HALF_PERIOD-1 that advances phases.
REQ-020 IDLE/HALT: core clock = 0, core reset = 1 (IDLE) or 0 (HALT), instruction held; start SHALL move to CRST and clear cycle_count, done and timeout.
REQ-021 start with load_en in the same cycle: the write SHALL occur and start SHALL be accepted; the run SHALL see the new word.
REQ-022 CRST: core reset = 1 for one full core-clock period (high then low half), instruction = mem[0]; then the FSM SHALL go to RUN_HI.
REQ-023 RUN_HI: core clock = 1, core reset = 0.
  - On the last clk cycle of RUN_HI: pc_val <= core_out; the instruction register <= mem[core_out[4:0]].
  - The new instruction SHALL be visible on core_io[5:0] from the first cycle of RUN_LO (one-clk fetch latency).
REQ-024 RUN_LO: core clock = 0.
  - On the last clk cycle: x8_val <= core_out and cycle_count increments.
  - Then the FSM SHALL go to RUN_HI, unless a halt condition holds.
REQ-025 Halt conditions, evaluated at the end of RUN_LO:
  - The PC sampled this cycle equals the PC sampled in the previous core cycle (self-jump) -> HALT, timeout = 0.
  - Else, incremented cycle_count == MAX_CYCLES -> HALT, timeout = 1.
  - The self-jump test SHALL have priority and SHALL NOT apply on the first core cycle after CRST.
REQ-026 PC values 32..255 SHALL wrap to mem[pc[4:0]] with no error flag.
REQ-027 cycle_count SHALL saturate at 255.
REQ-028 start while busy SHALL be ignored.
REQ-029 All outputs SHALL be registered; core_io SHALL be glitch-free (driven directly from flops).

Reset
REQ-030 While reset = 0, asynchronously:
  - FSM = IDLE; core_io = 8'h40 (clock 0, core reset 1, instruction 0).
  - pc_val, x8_val and cycle_count = 0; busy, done and timeout = 0.
REQ-031 Reset mid-run SHALL abort immediately to IDLE; memory SHALL be retained, so a later start SHALL replay the same program.

Verification
REQ-032 Reset release -> core_io = 8'h40, all status outputs 0, FSM in IDLE.
REQ-033 Load mem[0..3] = 6'h01, 6'h09, 6'h12, 6'h1B and pulse start; a McCoy model returns PC 0,1,2,3 -> core_io[5:0] sequence 01,09,12,1B, with each word appearing one clk after the high-phase sample.
REQ-034 Model PC stuck at 8'h05 from cycle 3 -> done = 1, timeout = 0, cycle_count = 4, pc_val = 8'h05.
REQ-035 MAX_CYCLES = 10 with an always-incrementing PC -> done = 1, timeout = 1, cycle_count = 10; core clock high time = HALF_PERIOD clks.
REQ-036 Model PC = 8'h25 -> instruction = mem[5]; load_en during RUN -> memory unchanged.
REQ-037 Assert reset in RUN_LO -> core_io = 8'h40 at once; a new start replays the program from mem[0].
